// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike instruction fetch path.
package risc_v_mike_pkg;

  localparam int INSTR_32_W = 32;

  typedef logic [31:0] t_pc_addr;

  // Largest supported instruction buffer; sizes every fetch counter.
  localparam int FETCH_FIFO_DEPTH_MAX = 8;
  localparam int FETCH_CNT_W          = $clog2(FETCH_FIFO_DEPTH_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } t_fetch_state;

  // Instruction addresses are word aligned; the two low bits are dropped.
  function automatic t_pc_addr pc_word_align(input t_pc_addr a);
    return a & ~t_pc_addr'(32'h3);
  endfunction

endpackage

// File: rtl/risc_v_mike_fetch_fifo.sv
// Small synchronous FIFO used for the instruction buffer and the PC tag queue.
// Push while full is accepted only together with a pop; flush empties it.
module risc_v_mike_fetch_fifo
  import risc_v_mike_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [FETCH_CNT_W-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [FETCH_CNT_W-1:0] r_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_do_push;
  logic                   w_do_pop;

  assign w_full    = (r_count == FETCH_CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && !w_empty;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; entries carry no reset, the empty flag masks stale contents.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_count     = r_count;

endmodule

// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction fetch unit: issues sequential word reads, buffers returned
// instructions with their PCs, and handles redirects by flushing and
// discarding responses of requests issued before the redirect.
// Optional feature macro: RISC_V_MIKE_FETCH_MISALIGN_EN adds the sticky
// fetch_misaligned output and blocks fetching after a misaligned redirect.
module risc_v_mike_fetch_unit
  import risc_v_mike_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef RISC_V_MIKE_FETCH_MISALIGN_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int            CW      = FETCH_CNT_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  t_fetch_state                r_state;
  t_pc_addr                    r_fetch_pc;
  logic [CW-1:0]               r_outstanding;
  logic [CW-1:0]               r_stale;

  logic [CW-1:0]               w_fifo_count;
  logic [CW-1:0]               w_tag_count;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic                        w_tag_full;
  logic                        w_tag_empty;
  logic [INSTR_32_W+31:0]      w_fifo_head;
  t_pc_addr                    w_tag_head;
  t_pc_addr                    w_redirect_target;
  logic                        w_room;
  logic                        w_req_valid;
  logic                        w_req_fire;
  logic                        w_rsp_in_flight;
  logic                        w_rsp_accept;
  logic                        w_rsp_stale_drop;
  logic                        w_instr_pop;
  logic                        w_fetch_block;
  logic [CW-1:0]               w_redirect_stale;
  logic [CW-1:0]               w_stale_after;
  logic                        w_unused_flags;

  assign w_redirect_target = pc_word_align(redirect_pc);

`ifdef RISC_V_MIKE_FETCH_MISALIGN_EN
  logic r_misaligned;

  // Sticky misalignment flag, re-evaluated on every redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_misaligned <= 1'b0;
    else if (redirect_valid) r_misaligned <= |redirect_pc[1:0];
  end

  assign w_fetch_block    = r_misaligned;
  assign fetch_misaligned = r_misaligned;
`else
  assign w_fetch_block = 1'b0;
`endif

  // Requests in flight plus buffered instructions never exceed the buffer size,
  // so every accepted response is guaranteed a free FIFO slot.
  assign w_room           = (r_outstanding + w_fifo_count) < DEPTH_C;
  assign w_req_valid      = (r_state == FETCH) && w_room && !redirect_valid && !w_fetch_block;
  assign w_req_fire       = w_req_valid && imem_req_ready;
  // A response with nothing in flight belongs to a request abandoned by reset.
  assign w_rsp_in_flight  = imem_rsp_valid && ((r_stale != '0) || (r_outstanding != '0));
  assign w_rsp_accept     = imem_rsp_valid && !redirect_valid && (r_stale == '0) && (r_outstanding != '0);
  assign w_rsp_stale_drop = imem_rsp_valid && !redirect_valid && (r_stale != '0);
  assign w_redirect_stale = r_stale + r_outstanding + CW'(w_req_fire) - CW'(w_rsp_in_flight);
  assign w_stale_after    = r_stale - CW'(w_rsp_stale_drop);
  assign w_instr_pop      = instr_valid && instr_ready;

  // Fetch FSM with PC, outstanding and stale counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_stale       <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_target;
      r_outstanding <= '0;
      r_stale       <= w_redirect_stale;
      r_state       <= (w_redirect_stale != '0) ? DRAIN : FETCH;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_accept);
      r_stale       <= w_stale_after;
      case (r_state)
        IDLE:    r_state <= FETCH;
        DRAIN:   if (w_stale_after == '0) r_state <= FETCH;
        default: r_state <= r_state;
      endcase
    end
  end

  // Instruction buffer: {instruction word, PC}; redirect flush follows any same-cycle pop.
  risc_v_mike_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_32_W + 32)
  ) u_instr_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_flush     (redirect_valid),
    .i_push      (w_rsp_accept),
    .i_push_data ({imem_rsp_data, w_tag_head}),
    .i_pop       (w_instr_pop),
    .o_head_data (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // PC tag queue for live requests; stale responses never consult it.
  risc_v_mike_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tag_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_flush     (redirect_valid),
    .i_push      (w_req_fire),
    .i_push_data (r_fetch_pc),
    .i_pop       (w_rsp_accept),
    .o_head_data (w_tag_head),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty),
    .o_count     (w_tag_count)
  );

  assign w_unused_flags = ^{w_fifo_full, w_tag_full, w_tag_empty, w_tag_count};

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = !w_fifo_empty;
  assign instr          = w_fifo_head[INSTR_32_W+31:32];
  assign instr_pc       = w_fifo_head[31:0];

endmodule

// File: tb/tb_risc_v_mike_fetch_unit.sv
// Bench for risc_v_mike_fetch_unit: in-order memory model with variable
// latency, and a reference model of the expected instruction stream
// (sequential word PCs restarting at each redirect target).
module tb_risc_v_mike_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef RISC_V_MIKE_FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  risc_v_mike_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef RISC_V_MIKE_FETCH_MISALIGN_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int          total, bad, cyc, lat_min, lat_max, live, last_due;
  logic [31:0] exp_pc, exp_req;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  bit          stray_rsp, wrap_seen, prev_fire_valid;
  logic [31:0] prev_fire_addr;
  bit          p_valid, p_fire, p_redir;
  logic [31:0] p_addr;
  bit          s_req_valid, s_fire, s_iv, s_hs, s_redir_done;
  logic [31:0] s_req_addr, s_ipc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  // rmode: 0 no redirect, 1 redirect, 2 redirect only when an instr handshake and a response coincide.
  task automatic tick(input bit mrdy, input bit drdy, input int rmode, input logic [31:0] rpc);
    bit fire, hs, redir;
    int due;
    imem_req_ready = mrdy;
    instr_ready    = drdy;
    redirect_valid = (rmode == 1);
    redirect_pc    = rpc;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else if (stray_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      stray_rsp      = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (rmode == 2 && instr_valid && drdy && imem_rsp_valid) begin
      redirect_valid = 1'b1;
      #1;
    end
    redir = redirect_valid;
    fire  = imem_req_valid && mrdy;
    hs    = instr_valid && drdy;
    if (redir) chk("req_during_redirect", imem_req_valid, 0);
    if (p_valid && !p_fire && !p_redir && !redir) begin
      chk("req_hold_valid", imem_req_valid, 1);
      chk("req_hold_addr", imem_req_addr, p_addr);
    end
    if (fire) begin
      chk("req_addr", imem_req_addr, exp_req);
      chk("inflight_bound", live < DEPTH, 1);
      if (prev_fire_valid && prev_fire_addr == 32'hFFFF_FFFC && imem_req_addr == 32'h0) wrap_seen = 1'b1;
      prev_fire_valid = 1'b1;
      prev_fire_addr  = imem_req_addr;
      exp_req += 32'd4;
      live++;
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(due);
    end
    if (hs) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_word", instr, memf(exp_pc));
      exp_pc += 32'd4;
      live--;
    end
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_fire       = fire;
    s_iv         = instr_valid;
    s_hs         = hs;
    s_ipc        = instr_pc;
    s_redir_done = redir;
    if (redir) begin
      exp_pc          = rpc & ~32'h3;
      exp_req         = rpc & ~32'h3;
      live            = 0;
      prev_fire_valid = 1'b0;
    end
    p_valid = imem_req_valid;
    p_fire  = fire;
    p_redir = redir;
    p_addr  = imem_req_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    instr_ready    = 1'b1;
    for (int k = 0; k < n; k++) begin
      imem_req_ready = 1'($urandom);
      imem_rsp_valid = 1'($urandom);
      imem_rsp_data  = $urandom;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
`ifdef RISC_V_MIKE_FETCH_MISALIGN_EN
      chk("rst_misaligned", fetch_misaligned, 0);
`endif
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    rst = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    last_due        = cyc;
    exp_pc          = RST_PC;
    exp_req         = RST_PC;
    live            = 0;
    prev_fire_valid = 1'b0;
    p_valid         = 1'b0;
  endtask

  initial begin
    int  fires, reqs;
    bit  found;
    total = 0; bad = 0; cyc = 0; lat_min = 1; lat_max = 1;
    stray_rsp = 1'b0; wrap_seen = 1'b0;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
    @(negedge clk);

    // Reset release, IDLE for one cycle, first fetches, 2-cycle latency; a stray pre-reset response is ignored.
    do_reset(3);
    stray_rsp = 1'b1;
    tick(1, 1, 0, 0); chk("idle_after_reset", s_req_valid, 0);
    tick(1, 1, 0, 0); chk("first_req_valid", s_req_valid, 1); chk("first_req_addr", s_req_addr, 32'h0);
    tick(1, 1, 0, 0); chk("no_instr_yet", s_iv, 0); chk("second_req_addr", s_req_addr, 32'h4);
    tick(1, 1, 0, 0); chk("instr_valid_lat2", s_iv, 1); chk("instr_pc_first", s_ipc, 32'h0);
    for (int k = 0; k < 10; k++) tick(1, 1, 0, 0);

    // Decode stalled: buffer fills, exactly DEPTH requests, head held.
    do_reset(2);
    fires = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1, 0, 0, 0);
      if (s_fire) fires++;
    end
    chk("stall_requests", fires, DEPTH);
    chk("stall_instr_valid", s_iv, 1);
    chk("stall_head_pc", s_ipc, 32'h0);
    for (int k = 0; k < 10; k++) tick(1, 1, 0, 0);

    // Redirect with two requests outstanding on a slow memory.
    do_reset(2);
    lat_min = 4; lat_max = 4;
    tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    chk("outstanding_before_redirect", mq_addr.size(), 2);
    tick(1, 1, 1, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1, 1, 0, 0);
      if (s_hs) begin
        found = 1'b1;
        chk("redirect_first_pc", s_ipc, 32'h100);
      end
    end
    chk("redirect_hs_seen", found, 1);
    lat_min = 1; lat_max = 1;

    // Redirect coinciding with an instr handshake and a memory response.
    do_reset(2);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1, 1, 2, 32'h300);
      found = s_redir_done;
    end
    chk("coincident_redirect_seen", found, 1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1, 1, 0, 0);
      if (s_hs) begin
        found = 1'b1;
        chk("coincident_next_pc", s_ipc, 32'h300);
      end
    end
    chk("coincident_hs_seen", found, 1);

    // PC wrap from 0xFFFF_FFFC to 0x0.
    wrap_seen = 1'b0;
    tick(1, 1, 1, 32'hFFFF_FFF8);
    for (int k = 0; k < 15; k++) tick(1, 1, 0, 0);
    chk("wrap_seen", wrap_seen, 1);

`ifdef RISC_V_MIKE_FETCH_MISALIGN_EN
    // Misaligned redirect blocks fetching until an aligned redirect.
    tick(1, 1, 1, 32'h102);
    chk("misaligned_set", fetch_misaligned, 1);
    reqs = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1, 1, 0, 0);
      if (s_req_valid) reqs++;
    end
    chk("misaligned_no_req", reqs, 0);
    tick(1, 1, 1, 32'h200);
    chk("misaligned_clear", fetch_misaligned, 0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1, 1, 0, 0);
      if (s_fire) begin
        found = 1'b1;
        chk("misaligned_resume_addr", s_req_addr, 32'h200);
      end
    end
    chk("misaligned_resume_seen", found, 1);
`else
    reqs = 0;
`endif

    // Randomized traffic with random redirects and one mid-run reset.
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] tgt;
      bit          mr, dr, rd;
      if (k == 700) begin
        do_reset(2);
        stray_rsp = 1'b1;
      end
      mr  = ($urandom_range(0, 9) < 7);
      dr  = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 99) < 3);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      tick(mr, dr, rd ? 1 : 0, tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
